// File: rtl/ctrl_unit_mc_pkg.sv
// Shared encodings for the multicycle control unit: instruction fields, ALU/shifter
// operations, datapath mux selects, FSM states and the registered control word.
package ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_SRL = 6'h02;
    localparam logic [5:0] FN_SRA = 6'h03;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;

    localparam logic [2:0] ALU_LOAD = 3'd0;
    localparam logic [2:0] ALU_ADD  = 3'd1;
    localparam logic [2:0] ALU_SUB  = 3'd2;
    localparam logic [2:0] ALU_AND  = 3'd3;
    localparam logic [2:0] ALU_INC  = 3'd4;
    localparam logic [2:0] ALU_NOT  = 3'd5;
    localparam logic [2:0] ALU_XOR  = 3'd6;

    localparam logic [2:0] SHF_NOP  = 3'd0;
    localparam logic [2:0] SHF_LOAD = 3'd1;
    localparam logic [2:0] SHF_SLL  = 3'd2;
    localparam logic [2:0] SHF_SRL  = 3'd3;
    localparam logic [2:0] SHF_SRA  = 3'd4;

    localparam logic [1:0] IORD_PC     = 2'd0;
    localparam logic [1:0] IORD_ALUOUT = 2'd1;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;
    localparam logic [1:0] PCSRC_EXC    = 2'd3;
    localparam logic [1:0] SRCB_B      = 2'd0;
    localparam logic [1:0] SRCB_FOUR   = 2'd1;
    localparam logic [1:0] SRCB_IMM    = 2'd2;
    localparam logic [1:0] SRCB_IMM_SH = 2'd3;
    localparam logic [2:0] M2R_ALUOUT = 3'd0;
    localparam logic [2:0] M2R_MDR    = 3'd1;
    localparam logic [2:0] M2R_SHIFT  = 3'd2;
    localparam logic [2:0] M2R_PC     = 3'd3;
    localparam logic [2:0] M2R_SP     = 3'd7;
    localparam logic [1:0] DST_RT = 2'd0;
    localparam logic [1:0] DST_RA = 2'd1;
    localparam logic [1:0] DST_SP = 2'd2;
    localparam logic [1:0] DST_RD = 2'd3;
    localparam logic [1:0] SAMT_SHAMT = 2'd2;

    typedef enum logic [5:0] {
        S_RST_SP, S_FETCH, S_IR_LOAD, S_DECODE,
        S_EXEC_R, S_EXEC_I, S_WB_R, S_WB_I,
        S_SH_LOAD, S_SH_RUN, S_SH_WB,
        S_MEM_ADDR, S_MEM_RD, S_MEM_WB, S_MEM_WR,
        S_BRANCH, S_JUMP, S_JAL,
        S_OVF_EXC, S_ILLEGAL, S_EXC_VEC
    } state_e;

    typedef struct packed {
        logic [1:0] i_or_d;
        logic [1:0] pc_source;
        logic       ir_write;
        logic       pc_write;
        logic       pc_write_cond;
        logic       memory_write;
        logic       reg_write;
        logic       a_b_write;
        logic       alu_out_write;
        logic       epc_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic [2:0] mem_to_reg;
        logic [1:0] reg_dist_ctrl;
        logic       shift_src_control;
        logic [2:0] shift_control;
        logic [1:0] shift_amount_control;
    } ctrl_t;

endpackage

// File: rtl/ctrl_unit_mc_if.sv
// Control-unit <-> datapath bundle: instruction fields and ALU flags in, mux selects
// and write enables out. master = control unit, slave = datapath.
interface ctrl_unit_mc_if;
    logic [5:0] op_code;
    logic [5:0] funct;
    logic       alu_overflow;
    logic       alu_zero;
    logic [1:0] i_or_d;
    logic [1:0] pc_source;
    logic       ir_write;
    logic       pc_write;
    logic       pc_write_cond;
    logic       memory_write;
    logic       reg_write;
    logic       a_b_write;
    logic       alu_out_write;
    logic       epc_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [2:0] mem_to_reg;
    logic [1:0] reg_dist_ctrl;
    logic       shift_src_control;
    logic [2:0] shift_control;
    logic [1:0] shift_amount_control;
    logic [5:0] state_dbg;

    modport master (
        input  op_code, funct, alu_overflow, alu_zero,
        output i_or_d, pc_source, ir_write, pc_write, pc_write_cond, memory_write,
               reg_write, a_b_write, alu_out_write, epc_write, alu_src_a, alu_src_b,
               alu_op, mem_to_reg, reg_dist_ctrl, shift_src_control, shift_control,
               shift_amount_control, state_dbg
    );

    modport slave (
        output op_code, funct, alu_overflow, alu_zero,
        input  i_or_d, pc_source, ir_write, pc_write, pc_write_cond, memory_write,
               reg_write, a_b_write, alu_out_write, epc_write, alu_src_a, alu_src_b,
               alu_op, mem_to_reg, reg_dist_ctrl, shift_src_control, shift_control,
               shift_amount_control, state_dbg
    );
endinterface

// File: rtl/ctrl_unit_mc_mem_wait_cnt.sv
// Loadable saturating down-counter timing memory accesses; done when it reaches zero,
// last one cycle earlier so a registered output can be raised for the final wait cycle.
module mem_wait_cnt #(
    parameter int WIDTH = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic             dec,
    input  logic [WIDTH-1:0] load_val,
    output logic             done,
    output logic             last
);
    logic [WIDTH-1:0] count_reg;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_val;
        end else if (dec && count_reg != '0) begin
            count_reg <= count_reg - 1'b1;
        end
    end

    assign done = (count_reg == '0);
    assign last = (count_reg == WIDTH'(1));
endmodule

// File: rtl/ctrl_unit_mc.sv
// Multicycle MIPS-subset control FSM: outputs are registered from the state being
// entered, except the branch PC write which needs the live ALU zero flag.
module ctrl_unit_mc
    import ctrl_pkg::*;
#(
    parameter int MEM_WAIT    = 2,
    parameter int SP_REG_INIT = 1,
    parameter int EXC_EN      = 1
) (
    input  logic           clock,
    input  logic           reset,
    ctrl_unit_mc_if.master bus
);
    localparam logic [2:0] WAIT_LOAD = 3'(MEM_WAIT - 1);

    state_e state_reg, state_next;
    ctrl_t  ctl_reg, ctl_next;
    logic   sp_done_reg, br_en_reg, br_ne_reg;
    logic   cnt_load, cnt_done, cnt_last;
    logic   r_arith, r_shift, ovf_trap;

    // The counter reloads in every state that does not wait, so it is primed on entry.
    assign cnt_load = !(state_reg == S_FETCH || state_reg == S_MEM_RD);

    mem_wait_cnt #(.WIDTH(3)) u_wait (
        .clock    (clock),
        .reset    (reset),
        .load     (cnt_load),
        .dec      (!cnt_load),
        .load_val (WAIT_LOAD),
        .done     (cnt_done),
        .last     (cnt_last)
    );

    assign r_arith = (bus.op_code == OP_RTYPE) &&
                     (bus.funct == FN_ADD || bus.funct == FN_SUB || bus.funct == FN_AND);
    assign r_shift = (bus.op_code == OP_RTYPE) &&
                     (bus.funct == FN_SLL || bus.funct == FN_SRL || bus.funct == FN_SRA);

    always_comb begin
        ovf_trap = 1'b0;
        if (EXC_EN != 0 && bus.alu_overflow) begin
            if (state_reg == S_EXEC_R)      ovf_trap = (bus.funct != FN_AND);
            else if (state_reg == S_EXEC_I) ovf_trap = (bus.op_code == OP_ADDI);
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_RST_SP:   if (SP_REG_INIT == 0 || sp_done_reg) state_next = S_FETCH;
            S_FETCH:    if (cnt_done) state_next = S_IR_LOAD;
            S_IR_LOAD:  state_next = S_DECODE;
            S_DECODE: begin
                if (r_arith)      state_next = S_EXEC_R;
                else if (r_shift) state_next = S_SH_LOAD;
                else begin
                    case (bus.op_code)
                        OP_ADDI, OP_ADDIU: state_next = S_EXEC_I;
                        OP_LW, OP_SW:      state_next = S_MEM_ADDR;
                        OP_BEQ, OP_BNE:    state_next = S_BRANCH;
                        OP_J:              state_next = S_JUMP;
                        OP_JAL:            state_next = S_JAL;
                        default:           state_next = (EXC_EN != 0) ? S_ILLEGAL : S_FETCH;
                    endcase
                end
            end
            S_EXEC_R:   state_next = ovf_trap ? S_OVF_EXC : S_WB_R;
            S_EXEC_I:   state_next = ovf_trap ? S_OVF_EXC : S_WB_I;
            S_SH_LOAD:  state_next = S_SH_RUN;
            S_SH_RUN:   state_next = S_SH_WB;
            S_MEM_ADDR: state_next = (bus.op_code == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:   if (cnt_done) state_next = S_MEM_WB;
            S_OVF_EXC, S_ILLEGAL: state_next = S_EXC_VEC;
            default:    state_next = S_FETCH;
        endcase
    end

    always_comb begin
        ctl_next = '0;
        case (state_next)
            S_RST_SP: begin
                ctl_next.reg_write     = 1'b1;
                ctl_next.mem_to_reg    = M2R_SP;
                ctl_next.reg_dist_ctrl = DST_SP;
            end
            S_FETCH: begin
                ctl_next.i_or_d    = IORD_PC;
                ctl_next.alu_src_b = SRCB_FOUR;
                ctl_next.alu_op    = ALU_ADD;
                ctl_next.pc_write  = (state_reg == S_FETCH) ? cnt_last : (MEM_WAIT == 1);
            end
            S_IR_LOAD: ctl_next.ir_write = 1'b1;
            S_DECODE: begin
                ctl_next.a_b_write     = 1'b1;
                ctl_next.alu_out_write = 1'b1;
                ctl_next.alu_src_b     = SRCB_IMM_SH;
                ctl_next.alu_op        = ALU_ADD;
            end
            S_EXEC_R, S_EXEC_I, S_MEM_ADDR: begin
                ctl_next.alu_src_a     = 1'b1;
                ctl_next.alu_out_write = 1'b1;
                ctl_next.alu_src_b     = (state_next == S_EXEC_R) ? SRCB_B : SRCB_IMM;
                if (state_next != S_EXEC_R)    ctl_next.alu_op = ALU_ADD;
                else if (bus.funct == FN_ADD)  ctl_next.alu_op = ALU_ADD;
                else if (bus.funct == FN_SUB)  ctl_next.alu_op = ALU_SUB;
                else                           ctl_next.alu_op = ALU_AND;
            end
            S_WB_R, S_WB_I: begin
                ctl_next.reg_write     = 1'b1;
                ctl_next.mem_to_reg    = M2R_ALUOUT;
                ctl_next.reg_dist_ctrl = (state_next == S_WB_R) ? DST_RD : DST_RT;
            end
            S_SH_LOAD: begin
                ctl_next.shift_control        = SHF_LOAD;
                ctl_next.shift_amount_control = SAMT_SHAMT;
            end
            S_SH_RUN: begin
                if (bus.funct == FN_SLL)      ctl_next.shift_control = SHF_SLL;
                else if (bus.funct == FN_SRL) ctl_next.shift_control = SHF_SRL;
                else                          ctl_next.shift_control = SHF_SRA;
            end
            S_SH_WB: begin
                ctl_next.reg_write     = 1'b1;
                ctl_next.mem_to_reg    = M2R_SHIFT;
                ctl_next.reg_dist_ctrl = DST_RD;
            end
            S_MEM_RD: ctl_next.i_or_d = IORD_ALUOUT;
            S_MEM_WB: begin
                ctl_next.reg_write     = 1'b1;
                ctl_next.mem_to_reg    = M2R_MDR;
                ctl_next.reg_dist_ctrl = DST_RT;
            end
            S_MEM_WR: begin
                ctl_next.i_or_d       = IORD_ALUOUT;
                ctl_next.memory_write = 1'b1;
            end
            S_BRANCH: begin
                ctl_next.alu_src_a = 1'b1;
                ctl_next.alu_src_b = SRCB_B;
                ctl_next.alu_op    = ALU_SUB;
                ctl_next.pc_source = PCSRC_ALUOUT;
            end
            S_JUMP, S_JAL: begin
                ctl_next.pc_source = PCSRC_JUMP;
                ctl_next.pc_write  = 1'b1;
                if (state_next == S_JAL) begin
                    ctl_next.reg_write     = 1'b1;
                    ctl_next.mem_to_reg    = M2R_PC;
                    ctl_next.reg_dist_ctrl = DST_RA;
                end
            end
            S_OVF_EXC, S_ILLEGAL: begin
                ctl_next.epc_write = 1'b1;
                ctl_next.alu_src_b = SRCB_FOUR;
                ctl_next.alu_op    = ALU_SUB;
            end
            S_EXC_VEC: begin
                ctl_next.pc_source = PCSRC_EXC;
                ctl_next.pc_write  = 1'b1;
            end
            default: ctl_next = '0;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg   <= S_RST_SP;
            ctl_reg     <= '0;
            sp_done_reg <= 1'b0;
            br_en_reg   <= 1'b0;
            br_ne_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            ctl_reg   <= ctl_next;
            if (state_reg == S_RST_SP) sp_done_reg <= 1'b1;
            br_en_reg <= (state_next == S_BRANCH);
            br_ne_reg <= (bus.op_code == OP_BNE);
        end
    end

    assign bus.i_or_d               = ctl_reg.i_or_d;
    assign bus.pc_source            = ctl_reg.pc_source;
    assign bus.ir_write             = ctl_reg.ir_write;
    assign bus.pc_write             = ctl_reg.pc_write | (br_en_reg & (bus.alu_zero ^ br_ne_reg));
    assign bus.pc_write_cond        = ctl_reg.pc_write_cond;
    assign bus.memory_write         = ctl_reg.memory_write;
    assign bus.reg_write            = ctl_reg.reg_write;
    assign bus.a_b_write            = ctl_reg.a_b_write;
    assign bus.alu_out_write        = ctl_reg.alu_out_write;
    assign bus.epc_write            = ctl_reg.epc_write;
    assign bus.alu_src_a            = ctl_reg.alu_src_a;
    assign bus.alu_src_b            = ctl_reg.alu_src_b;
    assign bus.alu_op               = ctl_reg.alu_op;
    assign bus.mem_to_reg           = ctl_reg.mem_to_reg;
    assign bus.reg_dist_ctrl        = ctl_reg.reg_dist_ctrl;
    assign bus.shift_src_control    = ctl_reg.shift_src_control;
    assign bus.shift_control        = ctl_reg.shift_control;
    assign bus.shift_amount_control = ctl_reg.shift_amount_control;
    assign bus.state_dbg            = state_reg;
endmodule

// File: tb/tb_ctrl_unit_mc.sv
// Bench for ctrl_unit_mc: each instruction's expected per-cycle control words are
// queued from an instruction-level model; a negedge monitor pops and compares.
module tb_ctrl_unit_mc;
    localparam int MW = 4;

    typedef struct packed {
        logic [1:0] i_or_d;
        logic [1:0] pc_source;
        logic       ir_write, pc_write, pc_write_cond, memory_write;
        logic       reg_write, a_b_write, alu_out_write, epc_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic [2:0] mem_to_reg;
        logic [1:0] reg_dist_ctrl;
        logic       shift_src_control;
        logic [2:0] shift_control;
        logic [1:0] shift_amount_control;
    } ctl_t;

    logic clock = 1'b0;
    logic reset = 1'b0;
    ctrl_unit_mc_if bus ();

    ctrl_unit_mc #(.MEM_WAIT(MW), .SP_REG_INIT(1), .EXC_EN(1)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    ctl_t  exp_q[$];
    string tag_q[$];
    int    checks = 0;
    int    errors = 0;
    int    push_left = -1;
    ctl_t  mon_exp, mon_act;
    string mon_tag;

    function automatic ctl_t dut_ctl();
        ctl_t a;
        a.i_or_d = bus.i_or_d;               a.pc_source = bus.pc_source;
        a.ir_write = bus.ir_write;           a.pc_write = bus.pc_write;
        a.pc_write_cond = bus.pc_write_cond; a.memory_write = bus.memory_write;
        a.reg_write = bus.reg_write;         a.a_b_write = bus.a_b_write;
        a.alu_out_write = bus.alu_out_write; a.epc_write = bus.epc_write;
        a.alu_src_a = bus.alu_src_a;         a.alu_src_b = bus.alu_src_b;
        a.alu_op = bus.alu_op;               a.mem_to_reg = bus.mem_to_reg;
        a.reg_dist_ctrl = bus.reg_dist_ctrl; a.shift_src_control = bus.shift_src_control;
        a.shift_control = bus.shift_control; a.shift_amount_control = bus.shift_amount_control;
        return a;
    endfunction

    always @(negedge clock) begin
        if (exp_q.size() != 0) begin
            mon_exp = exp_q.pop_front();
            mon_tag = tag_q.pop_front();
            mon_act = dut_ctl();
            checks++;
            if (mon_act !== mon_exp) begin
                errors++;
                $display("FAIL %s: actual=%h required=%h", mon_tag, mon_act, mon_exp);
            end
        end
    end

    task automatic exp(input string tag, input ctl_t c);
        if (push_left != 0) begin
            exp_q.push_back(c);
            tag_q.push_back(tag);
            if (push_left > 0) push_left--;
        end
    endtask

    task automatic exc_seq(input string nm);
        ctl_t c;
        c = '0; c.epc_write = 1'b1; c.alu_src_b = 2'd1; c.alu_op = 3'd2;
        exp({nm, ":epc"}, c);
        c = '0; c.pc_source = 2'd3; c.pc_write = 1'b1;
        exp({nm, ":vector"}, c);
    endtask

    // Instruction-level reference: the cycle-by-cycle control words one instruction produces.
    task automatic model_instr(input string nm, input logic [5:0] op, input logic [5:0] fn,
                               input bit ovf, input bit zero);
        ctl_t c;
        bit r_arith, r_shift, trap;
        for (int i = 0; i < MW; i++) begin
            c = '0; c.alu_src_b = 2'd1; c.alu_op = 3'd1; c.pc_write = (i == MW - 1);
            exp({nm, ":fetch"}, c);
        end
        c = '0; c.ir_write = 1'b1;
        exp({nm, ":ir_load"}, c);
        c = '0; c.a_b_write = 1'b1; c.alu_out_write = 1'b1; c.alu_src_b = 2'd3; c.alu_op = 3'd1;
        exp({nm, ":decode"}, c);
        r_arith = (op == 6'h00) && (fn == 6'h20 || fn == 6'h22 || fn == 6'h24);
        r_shift = (op == 6'h00) && (fn == 6'h00 || fn == 6'h02 || fn == 6'h03);
        if (r_arith || op == 6'h08 || op == 6'h09) begin
            c = '0; c.alu_src_a = 1'b1; c.alu_out_write = 1'b1;
            if (r_arith) begin
                c.alu_src_b = 2'd0;
                c.alu_op = (fn == 6'h20) ? 3'd1 : (fn == 6'h22) ? 3'd2 : 3'd3;
                trap = ovf && (fn != 6'h24);
            end else begin
                c.alu_src_b = 2'd2; c.alu_op = 3'd1;
                trap = ovf && (op == 6'h08);
            end
            exp({nm, ":exec"}, c);
            if (trap) exc_seq(nm);
            else begin
                c = '0; c.reg_write = 1'b1; c.reg_dist_ctrl = r_arith ? 2'd3 : 2'd0;
                exp({nm, ":wb"}, c);
            end
        end else if (r_shift) begin
            c = '0; c.shift_control = 3'd1; c.shift_amount_control = 2'd2;
            exp({nm, ":sh_load"}, c);
            c = '0; c.shift_control = (fn == 6'h00) ? 3'd2 : (fn == 6'h02) ? 3'd3 : 3'd4;
            exp({nm, ":sh_run"}, c);
            c = '0; c.reg_write = 1'b1; c.mem_to_reg = 3'd2; c.reg_dist_ctrl = 2'd3;
            exp({nm, ":sh_wb"}, c);
        end else if (op == 6'h23 || op == 6'h2b) begin
            c = '0; c.alu_src_a = 1'b1; c.alu_src_b = 2'd2; c.alu_op = 3'd1; c.alu_out_write = 1'b1;
            exp({nm, ":mem_addr"}, c);
            if (op == 6'h23) begin
                for (int i = 0; i < MW; i++) begin
                    c = '0; c.i_or_d = 2'd1;
                    exp({nm, ":mem_rd"}, c);
                end
                c = '0; c.reg_write = 1'b1; c.mem_to_reg = 3'd1;
                exp({nm, ":mem_wb"}, c);
            end else begin
                c = '0; c.i_or_d = 2'd1; c.memory_write = 1'b1;
                exp({nm, ":mem_wr"}, c);
            end
        end else if (op == 6'h04 || op == 6'h05) begin
            c = '0; c.alu_src_a = 1'b1; c.alu_op = 3'd2; c.pc_source = 2'd1;
            c.pc_write = (op == 6'h04) ? zero : !zero;
            exp({nm, ":branch"}, c);
        end else if (op == 6'h02 || op == 6'h03) begin
            c = '0; c.pc_source = 2'd2; c.pc_write = 1'b1;
            if (op == 6'h03) begin c.reg_write = 1'b1; c.mem_to_reg = 3'd3; c.reg_dist_ctrl = 2'd1; end
            exp({nm, ":jump"}, c);
        end else begin
            exc_seq(nm);
        end
    endtask

    task automatic wait_drain();
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 200) begin
            @(posedge clock);
            k++;
        end
        if (exp_q.size() != 0) begin
            checks++; errors++;
            $display("FAIL drain_timeout: actual=%0d pending required=0", exp_q.size());
            exp_q.delete(); tag_q.delete();
        end
    endtask

    // Called with the DUT just having entered FETCH (or about to), so the new
    // instruction fields are in place long before DECODE.
    task automatic run_instr(input string nm, input logic [5:0] op, input logic [5:0] fn,
                             input bit ovf, input bit zero, input int limit);
        wait_drain();
        push_left = limit;
        model_instr(nm, op, fn, ovf, zero);
        push_left = -1;
        #1;
        bus.op_code = op; bus.funct = fn; bus.alu_overflow = ovf; bus.alu_zero = zero;
        $display("instr %-6s op=%h funct=%h ovf=%0d zero=%0d", nm, op, fn, ovf, zero);
    endtask

    task automatic check_reset_state(input string nm);
        checks++;
        if (dut_ctl() !== '0 || bus.pc_write !== 1'b0) begin
            errors++;
            $display("FAIL %s_outputs: actual=%h required=0", nm, dut_ctl());
        end
        checks++;
        if (bus.state_dbg !== 6'(ctrl_pkg::S_RST_SP)) begin
            errors++;
            $display("FAIL %s_state: actual=%0d required=%0d", nm, bus.state_dbg,
                     6'(ctrl_pkg::S_RST_SP));
        end
    endtask

    task automatic release_reset();
        ctl_t c;
        @(negedge clock); #1;
        c = '0; c.reg_write = 1'b1; c.mem_to_reg = 3'd7; c.reg_dist_ctrl = 2'd2;
        exp("reset:sp_init", c);
        reset = 1'b1;
    endtask

    task automatic pick(input int k, output string nm, output logic [5:0] op, output logic [5:0] fn);
        fn = 6'($urandom);
        case (k)
            0:  begin nm = "add";   op = 6'h00; fn = 6'h20; end
            1:  begin nm = "sub";   op = 6'h00; fn = 6'h22; end
            2:  begin nm = "and";   op = 6'h00; fn = 6'h24; end
            3:  begin nm = "sll";   op = 6'h00; fn = 6'h00; end
            4:  begin nm = "srl";   op = 6'h00; fn = 6'h02; end
            5:  begin nm = "sra";   op = 6'h00; fn = 6'h03; end
            6:  begin nm = "rbad";  op = 6'h00; fn = 6'h25; end
            7:  begin nm = "addi";  op = 6'h08; end
            8:  begin nm = "addiu"; op = 6'h09; end
            9:  begin nm = "lw";    op = 6'h23; end
            10: begin nm = "sw";    op = 6'h2b; end
            11: begin nm = "beq";   op = 6'h04; end
            12: begin nm = "bne";   op = 6'h05; end
            13: begin nm = "j";     op = 6'h02; end
            14: begin nm = "jal";   op = 6'h03; end
            default: begin nm = "ill"; op = 6'h3f; end
        endcase
    endtask

    initial begin
        string nm;
        logic [5:0] op, fn;
        bus.op_code = 6'h00; bus.funct = 6'h00; bus.alu_overflow = 1'b0; bus.alu_zero = 1'b0;
        repeat (3) @(posedge clock);
        #1 check_reset_state("reset");
        release_reset();

        run_instr("add",   6'h00, 6'h20, 1'b0, 1'b0, -1);
        run_instr("add",   6'h00, 6'h20, 1'b1, 1'b0, -1);
        run_instr("addiu", 6'h09, 6'h11, 1'b1, 1'b0, -1);
        run_instr("addi",  6'h08, 6'h00, 1'b1, 1'b0, -1);
        run_instr("and",   6'h00, 6'h24, 1'b1, 1'b0, -1);
        run_instr("lw",    6'h23, 6'h00, 1'b0, 1'b0, -1);
        run_instr("sw",    6'h2b, 6'h00, 1'b0, 1'b0, -1);
        run_instr("beq",   6'h04, 6'h00, 1'b0, 1'b1, -1);
        run_instr("bne",   6'h05, 6'h00, 1'b0, 1'b1, -1);
        run_instr("jal",   6'h03, 6'h00, 1'b0, 1'b0, -1);
        run_instr("sra",   6'h00, 6'h03, 1'b0, 1'b0, -1);
        run_instr("ill",   6'h3f, 6'h00, 1'b0, 1'b0, -1);

        // lw cut short by reset in its second memory wait cycle.
        run_instr("lw_rst", 6'h23, 6'h00, 1'b0, 1'b0, MW + 4);
        wait_drain();
        #2 reset = 1'b0;
        #1 check_reset_state("midwait_reset");
        repeat (2) @(posedge clock);
        #1 check_reset_state("held_reset");
        release_reset();

        for (int n = 0; n < 40; n++) begin
            pick(int'($urandom_range(0, 15)), nm, op, fn);
            run_instr(nm, op, fn, 1'($urandom), 1'($urandom), -1);
        end
        wait_drain();
        repeat (2) @(posedge clock);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ctrl_unit_mc.md
Name: ctrl_unit_mc

Overview:
Parametrised multicycle control FSM for the MIPS-subset datapath and the next generation of the current control unit. Adds configurable memory wait states, an iterative shift sequence (sll/srl/sra), lw/sw, beq/bne, j/jal, and overflow/illegal-opcode exceptions. Sits beside the datapath and drives every mux select and write enable from op_code/funct plus ALU status flags.

Parameters:
MEM_WAIT, 2, cycles from address issue to valid memory data; legal range 1..7
SP_REG_INIT, 1, 1 enables the one-cycle post-reset stack-pointer write ($29 <- mem_to_reg source 7); 0 skips it
EXC_EN, 1, 1 enables overflow and illegal-op exception states; 0 means overflow is ignored and unknown opcodes return to FETCH

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low
op_code  in  6  IR[31:26]
funct  in  6  IR[5:0]
alu_overflow  in  1  ALU overflow flag, valid in EXEC cycles
alu_zero  in  1  ALU zero flag, valid in BRANCH
i_or_d  out  2  memory address select: 0=PC, 1=ALUOut, 2=exception vector
pc_source  out  2  0=ALU, 1=ALUOut, 2=jump target, 3=exception vector
ir_write, pc_write, pc_write_cond, memory_write, reg_write, a_b_write, alu_out_write, epc_write  out  1 each  write enables
alu_src_a  out  1  0=PC, 1=A
alu_src_b  out  2  0=B, 1=const 4, 2=sign-ext imm, 3=sign-ext imm<<2
alu_op  out  3  LOAD=0, ADD=1, SUB=2, AND=3, INC=4, NOT=5, XOR=6
mem_to_reg  out  3  0=ALUOut, 1=MDR, 2=shift reg, 3=PC, 7=SP init constant
reg_dist_ctrl  out  2  0=rt, 1=$31, 2=$29, 3=rd
shift_src_control  out  1  0=B, 1=A
shift_control  out  3  NOP=0, LOAD=1, SLL=2, SRL=3, SRA=4
shift_amount_control  out  2  0=B[4:0], 2=shamt
state_dbg  out  6  current state encoding

Behaviour:
- Async reset (reset=0): every output 0, state=RST_SP, wait counter=0. Outputs are registered and update on the clock edge that enters a state.
- RST_SP (only if SP_REG_INIT=1): reg_write=1, mem_to_reg=7, reg_dist_ctrl=2 for exactly one cycle, then FETCH. With SP_REG_INIT=0, reset goes straight to FETCH.
- FETCH: i_or_d=0, alu_src_a=0, alu_src_b=1, alu_op=ADD. Stays MEM_WAIT cycles on a down-counter. pc_write=1 only in the final wait cycle. Then IR_LOAD.
- IR_LOAD: ir_write=1 for one cycle, then DECODE.
- DECODE: a_b_write=1, alu_out_write=1, alu_src_b=3, alu_op=ADD (branch target). Dispatch:
  - R-type add/sub/and -> EXEC_R
  - sll/srl/sra -> SH_LOAD
  - addi/addiu -> EXEC_I
  - lw/sw -> MEM_ADDR
  - beq/bne -> BRANCH
  - j -> JUMP
  - jal -> JAL
  - anything else -> ILLEGAL
- EXEC_R: alu_src_a=1, alu_src_b=0, alu_op from funct, alu_out_write=1. Next is WB_R, or OVF_EXC if alu_overflow=1, EXC_EN=1, and the op is add/sub (never and).
- EXEC_I: same as EXEC_R but alu_src_b=2. Overflow checked for addi only, never addiu. Next is WB_I.
- WB_R / WB_I: reg_write=1, mem_to_reg=0, reg_dist_ctrl=3 / 0. Then FETCH. No write occurs on the overflow path.
- SH_LOAD: shift_control=LOAD, shift_src_control=0, shift_amount_control=2. Then SH_RUN.
- SH_RUN: shift_control = SLL/SRL/SRA by funct, one cycle. Then SH_WB.
- SH_WB: reg_write=1, mem_to_reg=2, reg_dist_ctrl=3. Then FETCH.
- MEM_ADDR: alu_src_a=1, alu_src_b=2, ADD, alu_out_write=1. Next is MEM_RD for lw, MEM_WR for sw.
- MEM_RD: i_or_d=1 for MEM_WAIT cycles. Then MEM_WB: reg_write=1, mem_to_reg=1, reg_dist_ctrl=0. Then FETCH.
- MEM_WR: i_or_d=1, memory_write=1 for exactly 1 cycle. Then FETCH.
- BRANCH: alu_src_a=1, alu_src_b=0, SUB, pc_source=1. pc_write=1 when (beq & alu_zero) | (bne & !alu_zero). Then FETCH.
- JUMP: pc_source=2, pc_write=1. Then FETCH.
- JAL: reg_write=1, mem_to_reg=3, reg_dist_ctrl=1, plus the JUMP controls in the same cycle. Then FETCH.
- OVF_EXC / ILLEGAL: epc_write=1 with alu_src_a=0, alu_src_b=1, alu_op=SUB (EPC=PC-4). Next cycle pc_source=3, pc_write=1. Then FETCH.
- All enables not listed for a state are 0 in that state. Selects not listed are 0.
- Reset asserted in any state, including mid-wait: immediate return to the reset values, counter cleared, no partial write completes after reset.

Decomposition:
- Package ctrl_pkg: opcode and funct constants, alu_op and shift_control encodings, state enum, mux select constants.
- One sub-module, mem_wait_cnt: a loadable down-counter with a done flag, shared by FETCH and MEM_RD.

Test Plan:
1. Reset release, SP_REG_INIT=1, MEM_WAIT=2 -> 1 cycle RST_SP (reg_write=1, mem_to_reg=7, reg_dist_ctrl=2); 2 FETCH cycles with pc_write only in the 2nd; then IR_LOAD and DECODE.
2. add, alu_overflow=0 -> EXEC_R then WB_R with reg_dist_ctrl=3. add with alu_overflow=1 -> OVF_EXC, epc_write=1, no reg_write, then pc_source=3, pc_write=1.
3. addiu with alu_overflow=1 -> no exception; WB_I writes rt.
4. lw with MEM_WAIT=4 -> i_or_d=1 for exactly 4 cycles, then reg_write=1 with mem_to_reg=1. sw -> memory_write high exactly 1 cycle.
5. beq with alu_zero=1 -> pc_write=1; bne with alu_zero=1 -> pc_write=0. jal -> reg_dist_ctrl=1, mem_to_reg=3, pc_source=2 in the same cycle.
6. sra -> shift_control sequence LOAD, SRA, then SH_WB with mem_to_reg=2. Reset pulled low in the 2nd MEM_RD wait cycle -> all outputs 0 asynchronously, restart at RST_SP.
